spi_cfg_responder: RTL and testbench



---
 rtl/we_spi_pkg.sv | 17 +
 rtl/spi_shift_reg.sv | 38 +++
 rtl/spi_cfg_responder.sv | 150 +++++++++++++++
 tb/tb_spi_cfg_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/we_spi_pkg.sv
// Shared constants and state encoding for the weClk SPI config responder.
package we_spi_pkg;

    localparam int unsigned CFG_MSB_BITS = 8;
    localparam int unsigned CFG_LSB_BITS = 32;
    localparam int unsigned CFG_BITS_DEF = CFG_MSB_BITS + CFG_LSB_BITS;
    localparam int unsigned DAC_BITS_DEF = 16;
    localparam int unsigned CNT_BITS     = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SHIFT  = 2'd1;
    localparam state_t ST_COMMIT = 2'd2;
    localparam state_t ST_ERR    = 2'd3;

endpackage

// File: rtl/spi_shift_reg.sv
// Combined shift register and saturating bit counter. The register is loaded
// with the left-aligned readback word; received bits enter at the LSB while
// the readback leaves from the MSB, so one register serves both directions.
module spi_shift_reg #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             ser_in,
    input  logic [CNT_W-1:0] cnt_max,
    output logic             ser_out_c,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] bit_cnt
);

    // Load clears the count; each shift moves one bit in and counts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            data    <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            data    <= load_data;
            bit_cnt <= '0;
        end else if (shift_en) begin
            data <= {data[WIDTH-2:0], ser_in};
            if (bit_cnt != cnt_max) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    assign ser_out_c = data[WIDTH-1];

endmodule

// File: rtl/spi_cfg_responder.sv
// SPI responder: receives config or waveform frames, commits them on a
// correct length, and echoes the previously committed word back on miso.
module spi_cfg_responder
    import we_spi_pkg::*;
#(
    parameter int unsigned CFG_BITS = CFG_BITS_DEF,
    parameter int unsigned DAC_BITS = DAC_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                spi_sel,
    input  logic                cs_b,
    input  logic                mosi,
    output logic                clk_out,
    output logic                miso,
    output logic [CFG_BITS-1:0] cfg_reg,
    output logic                cfg_valid,
    output logic [DAC_BITS-1:0] dac_code,
    output logic                dac_valid,
    output logic                frame_err,
    output logic [CNT_BITS-1:0] frame_cnt
);

    localparam int unsigned BCW = $clog2(CFG_BITS + 2);

    state_t              state_q, state_d;
    logic                sel_q, sel_d;
    logic [BCW-1:0]      n_q, n_d;
    logic                armed_q;
    logic                clk_out_d, miso_d;
    logic [CFG_BITS-1:0] cfg_reg_d;
    logic [DAC_BITS-1:0] dac_code_d;
    logic                cfg_valid_d, dac_valid_d, frame_err_d;
    logic [CNT_BITS-1:0] frame_cnt_d;

    logic                load_c, shift_c, ser_out_c;
    logic [CFG_BITS-1:0] load_data_c;
    logic [CFG_BITS-1:0] shift_q;
    logic [BCW-1:0]      bit_cnt;
    logic [BCW-1:0]      cnt_max_c;

    assign cnt_max_c = n_q + BCW'(1);

    spi_shift_reg #(
        .WIDTH (CFG_BITS),
        .CNT_W (BCW)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (load_c),
        .load_data (load_data_c),
        .shift_en  (shift_c),
        .ser_in    (mosi),
        .cnt_max   (cnt_max_c),
        .ser_out_c (ser_out_c),
        .data      (shift_q),
        .bit_cnt   (bit_cnt)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        n_d         = n_q;
        clk_out_d   = 1'b0;
        miso_d      = 1'b0;
        cfg_reg_d   = cfg_reg;
        dac_code_d  = dac_code;
        cfg_valid_d = 1'b0;
        dac_valid_d = 1'b0;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt;
        load_c      = 1'b0;
        shift_c     = 1'b0;
        load_data_c = '0;

        case (state_q)
            ST_IDLE: begin
                if (!cs_b && armed_q) begin
                    state_d     = ST_SHIFT;
                    sel_d       = spi_sel;
                    n_d         = spi_sel ? BCW'(CFG_BITS) : BCW'(DAC_BITS);
                    load_c      = 1'b1;
                    load_data_c = spi_sel ? cfg_reg
                                          : (CFG_BITS'(dac_code) << (CFG_BITS - DAC_BITS));
                    miso_d      = load_data_c[CFG_BITS-1];
                end
            end
            ST_SHIFT: begin
                if (cs_b) begin
                    if (bit_cnt == n_q) begin
                        state_d     = ST_COMMIT;
                        frame_cnt_d = frame_cnt + CNT_BITS'(1);
                        if (sel_q) begin
                            cfg_reg_d   = shift_q;
                            cfg_valid_d = 1'b1;
                        end else begin
                            dac_code_d  = shift_q[DAC_BITS-1:0];
                            dac_valid_d = 1'b1;
                        end
                    end else begin
                        state_d     = ST_ERR;
                        frame_err_d = 1'b1;
                    end
                end else if (!clk_out) begin
                    shift_c   = 1'b1;
                    clk_out_d = 1'b1;
                    miso_d    = miso;
                end else begin
                    miso_d = ser_out_c;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; armed_q blocks a restart until cs_b is seen high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= 1'b0;
            n_q       <= '0;
            armed_q   <= 1'b0;
            clk_out   <= 1'b0;
            miso      <= 1'b0;
            cfg_reg   <= '0;
            dac_code  <= '0;
            cfg_valid <= 1'b0;
            dac_valid <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            n_q       <= n_d;
            armed_q   <= armed_q | cs_b;
            clk_out   <= clk_out_d;
            miso      <= miso_d;
            cfg_reg   <= cfg_reg_d;
            dac_code  <= dac_code_d;
            cfg_valid <= cfg_valid_d;
            dac_valid <= dac_valid_d;
            frame_err <= frame_err_d;
            frame_cnt <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_spi_cfg_responder.sv
// Directed and randomized frames against a word-level model of the responder.
module tb_spi_cfg_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_sel;
    logic        cs_b;
    logic        mosi;
    logic        clk_out;
    logic        miso;
    logic [39:0] cfg_reg;
    logic        cfg_valid;
    logic [15:0] dac_code;
    logic        dac_valid;
    logic        frame_err;
    logic [15:0] frame_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [39:0] m_cfg;
    logic [15:0] m_dac;
    logic [15:0] m_cnt;

    spi_cfg_responder dut (
        .clk       (clk),
        .rst       (rst),
        .spi_sel   (spi_sel),
        .cs_b      (cs_b),
        .mosi      (mosi),
        .clk_out   (clk_out),
        .miso      (miso),
        .cfg_reg   (cfg_reg),
        .cfg_valid (cfg_valid),
        .dac_code  (dac_code),
        .dac_valid (dac_valid),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs();
        check("cfg_reg",   64'(cfg_reg),   64'(m_cfg));
        check("dac_code",  64'(dac_code),  64'(m_dac));
        check("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
    endtask

    task automatic check_quiet();
        check("cfg_valid_idle", 64'(cfg_valid), 64'd0);
        check("dac_valid_idle", 64'(dac_valid), 64'd0);
        check("frame_err_idle", 64'(frame_err), 64'd0);
        check("clk_out_idle",   64'(clk_out),   64'd0);
        check("miso_idle",      64'(miso),      64'd0);
    endtask

    // One bit period: mosi set up before the rising clk_out, spi_sel scrambled.
    task automatic drive_bit(input logic b, input bit chk, input logic expb);
        @(negedge clk);
        check("clk_out_low", 64'(clk_out), 64'd0);
        if (chk) check("miso_bit", 64'(miso), 64'(expb));
        mosi = b;
        @(posedge clk);
        @(negedge clk);
        check("clk_out_high", 64'(clk_out), 64'd1);
        spi_sel = 1'($urandom);
        @(posedge clk);
    endtask

    // Whole frame of nbits, MSB first, with commit/error checks against the model.
    task automatic send_frame(input bit sel, input int nbits, input logic [63:0] data,
                              input bit b2b_in, input bit b2b_out);
        int  n;
        bit  ok;
        logic eb;
        n = sel ? 40 : 16;
        if (!b2b_in) @(negedge clk);
        cs_b    = 1'b0;
        spi_sel = sel;
        @(posedge clk);
        for (int i = 0; i < nbits; i++) begin
            eb = 1'b0;
            if (i < n) eb = sel ? m_cfg[39-i] : m_dac[15-i];
            drive_bit(data[nbits-1-i], (i < n), eb);
        end
        @(negedge clk);
        cs_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ok = (nbits == n);
        if (ok) begin
            if (sel) m_cfg = data[39:0];
            else     m_dac = data[15:0];
            m_cnt = m_cnt + 16'd1;
        end
        check("cfg_valid", 64'(cfg_valid), 64'(ok && sel));
        check("dac_valid", 64'(dac_valid), 64'(ok && !sel));
        check("frame_err", 64'(frame_err), 64'(!ok));
        check_regs();
        if (b2b_out) cs_b = 1'b0;
        @(negedge clk);
        check_quiet();
    endtask

    initial begin
        bit sel, b2b, nb2b;
        int n, len;

        rst = 1'b1; cs_b = 1'b1; spi_sel = 1'b0; mosi = 1'b0;
        m_cfg = '0; m_dac = '0; m_cnt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet();
        check_regs();
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Config commit, then echo of it during a zero frame
        send_frame(1'b1, 40, 64'hA5_1234_5678, 1'b0, 1'b0);
        send_frame(1'b1, 40, 64'h0, 1'b0, 1'b0);
        send_frame(1'b1, 40, 64'h3C_DEAD_BEEF, 1'b0, 1'b0);
        // Waveform commit and its echo
        send_frame(1'b0, 16, 64'hBEEF, 1'b0, 1'b0);
        send_frame(1'b0, 16, 64'h1234, 1'b0, 1'b0);
        // Short and long frames
        send_frame(1'b1, 39, 64'h7F_FFFF_FFFF, 1'b0, 1'b0);
        send_frame(1'b0, 17, 64'h1_FFFF, 1'b0, 1'b0);
        send_frame(1'b1, 41, 64'h1FF_FFFF_FFFF, 1'b0, 1'b0);
        // Back-to-back frames with cs_b dropped during commit
        send_frame(1'b1, 40, 64'h81_0203_0405, 1'b0, 1'b1);
        send_frame(1'b0, 16, 64'hC3A5, 1'b1, 1'b0);

        // Reset in the middle of a config frame, cs_b held low afterwards
        @(negedge clk);
        cs_b = 1'b0; spi_sel = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 20; i++) drive_bit(1'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_cfg = '0; m_dac = '0; m_cnt = '0;
        check_quiet();
        check_regs();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_restart_clk", 64'(clk_out), 64'd0);
            check("no_restart_err", 64'(frame_err), 64'd0);
        end
        check_regs();
        cs_b = 1'b1;
        @(posedge clk);
        send_frame(1'b1, 40, {$urandom, $urandom}, 1'b0, 1'b0);

        // Randomized frames
        b2b = 1'b0;
        for (int f = 0; f < 30; f++) begin
            sel = 1'($urandom);
            n   = sel ? 40 : 16;
            case ($urandom_range(0, 5))
                0:       len = n - 1;
                1:       len = n + 1;
                default: len = n;
            endcase
            nb2b = (f == 29) ? 1'b0 : 1'($urandom);
            send_frame(sel, len, {$urandom, $urandom}, b2b, nb2b);
            b2b = nb2b;
        end

        // Frame counter wrap from its top value
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.frame_cnt;
        m_cnt = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        check("frame_cnt_top", 64'(frame_cnt), 64'(m_cnt));
        send_frame(1'b0, 16, {$urandom, $urandom}, 1'b0, 1'b0);
        check("frame_cnt_wrap", 64'(frame_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
